// File: rtl/regfile_arbiter_pkg.sv
// Shared RegisterFile geometry, opcode encodings and arbiter state type
// for the APU register-file arbitration slice.
package regfile_arbiter_pkg;

   localparam int RF_DATA_WIDTH = 16;
   localparam int RF_ADDR_WIDTH = 4;
   localparam int RF_NUM_REGS   = 16;

   localparam logic RF_OP_READ  = 1'b0;
   localparam logic RF_OP_WRITE = 1'b1;

   typedef enum logic {
      ST_ARB  = 1'b0,
      ST_HOLD = 1'b1
   } arbState_t;

endpackage

// File: rtl/regfile_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after the
// pointer, wrapping modulo NUM_REQ; returns one-hot grant and its index.
module regfile_arbiter_rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [PTR_W-1:0]   o_index,
   output logic               o_valid
);

   always_comb begin
      logic             found;
      int               sum;
      logic [PTR_W-1:0] cand;
      found   = 1'b0;
      sum     = 0;
      cand    = '0;
      o_grant = '0;
      o_index = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = int'(i_ptr) + k;
         if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
         end
         cand = PTR_W'(sum);
         if (!found && i_req[cand]) begin
            found         = 1'b1;
            o_grant[cand] = 1'b1;
            o_index       = cand;
         end
      end
      o_valid = found;
   end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares the single-port RegisterFile between NUM_REQ requesters using
// round-robin arbitration with an optional bounded lock (HOLD).
module regfile_arbiter
   import regfile_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = RF_DATA_WIDTH,
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
   parameter int LOCK_MAX   = 8
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic [NUM_REQ-1:0]           i_reqValid,
   input  logic [NUM_REQ-1:0]           i_reqWrite,
   input  logic [NUM_REQ-1:0]           i_reqLock,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_reqSelect,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_reqData,
   output logic [NUM_REQ-1:0]           o_reqReady,
   output logic [NUM_REQ-1:0]           o_rspValid,
   output logic [DATA_WIDTH-1:0]        o_rspData,
   output logic                         o_rfOpcode,
   output logic [ADDR_WIDTH-1:0]        o_rfSelect,
   output logic [DATA_WIDTH-1:0]        o_rfDataIn,
   input  logic [DATA_WIDTH-1:0]        i_rfDataOut
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(LOCK_MAX + 1);

   arbState_t              r_state;
   logic [PTR_W-1:0]       r_rrPtr;
   logic [PTR_W-1:0]       r_owner;
   logic [CNT_W-1:0]       r_holdCnt;
   logic [NUM_REQ-1:0]     r_rspValid;
   logic [ADDR_WIDTH-1:0]  r_lastSelect;
   logic [DATA_WIDTH-1:0]  r_lastData;

   logic [NUM_REQ-1:0]     w_eligible;
   logic [PTR_W-1:0]       w_ptr;
   logic [NUM_REQ-1:0]     w_grant;
   logic [PTR_W-1:0]       w_winner;
   logic                   w_accept;
   logic                   w_winWrite;
   logic                   w_winLock;
   logic [ADDR_WIDTH-1:0]  w_winSelect;
   logic [DATA_WIDTH-1:0]  w_winData;
   logic [PTR_W-1:0]       w_nextPtrWin;
   logic [PTR_W-1:0]       w_nextPtrOwner;

   // In HOLD only the owner may compete; nothing is granted while reset is high.
   always_comb begin
      w_eligible = '0;
      if (!i_reset) begin
         if (r_state == ST_HOLD) begin
            w_eligible[r_owner] = i_reqValid[r_owner];
         end else begin
            w_eligible = i_reqValid;
         end
      end
   end

   assign w_ptr = (r_state == ST_HOLD) ? r_owner : r_rrPtr;

   regfile_arbiter_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_picker (
      .i_req   (w_eligible),
      .i_ptr   (w_ptr),
      .o_grant (w_grant),
      .o_index (w_winner),
      .o_valid (w_accept)
   );

   always_comb begin
      w_winWrite  = 1'b0;
      w_winLock   = 1'b0;
      w_winSelect = '0;
      w_winData   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_winWrite  = i_reqWrite[i];
            w_winLock   = i_reqLock[i];
            w_winSelect = i_reqSelect[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_winData   = i_reqData[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign w_nextPtrWin   = (w_winner == PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + PTR_W'(1);
   assign w_nextPtrOwner = (r_owner  == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner  + PTR_W'(1);

   // Arbiter FSM, lock counter and one-cycle read response tracking.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= ST_ARB;
         r_rrPtr      <= '0;
         r_owner      <= '0;
         r_holdCnt    <= '0;
         r_rspValid   <= '0;
         r_lastSelect <= '0;
         r_lastData   <= '0;
      end else begin
         r_rspValid <= (w_accept && !w_winWrite) ? w_grant : '0;
         if (w_accept) begin
            r_lastSelect <= w_winSelect;
            r_lastData   <= w_winData;
         end
         case (r_state)
            ST_ARB: begin
               if (w_accept) begin
                  r_rrPtr <= w_nextPtrWin;
                  if (w_winLock) begin
                     r_state   <= ST_HOLD;
                     r_owner   <= w_winner;
                     r_holdCnt <= CNT_W'(1);
                  end
               end
            end
            ST_HOLD: begin
               if ((w_accept && !w_winLock) || (r_holdCnt == CNT_W'(LOCK_MAX))) begin
                  r_state   <= ST_ARB;
                  r_rrPtr   <= w_nextPtrOwner;
                  r_holdCnt <= '0;
               end else begin
                  r_holdCnt <= r_holdCnt + CNT_W'(1);
               end
            end
            default: r_state <= ST_ARB;
         endcase
      end
   end

   assign o_reqReady = w_grant;
   // A response pending across a reset edge is dropped rather than delivered.
   assign o_rspValid = r_rspValid & {NUM_REQ{~i_reset}};
   assign o_rspData  = i_rfDataOut;
   assign o_rfOpcode = w_accept ? w_winWrite  : RF_OP_READ;
   assign o_rfSelect = w_accept ? w_winSelect : r_lastSelect;
   assign o_rfDataIn = w_accept ? w_winData   : r_lastData;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed vector table, a write-then-read
// sequence, and randomized traffic checked against a behavioural model.
module tb_regfile_arbiter;
   import regfile_arbiter_pkg::*;

   localparam int N        = 4;
   localparam int DW       = 16;
   localparam int AW       = 4;
   localparam int LOCK_MAX = 8;

   logic            clk;
   logic            reset;
   logic [N-1:0]    reqValid, reqWrite, reqLock;
   logic [N*AW-1:0] reqSelect;
   logic [N*DW-1:0] reqData;
   logic [N-1:0]    reqReady, rspValid;
   logic [DW-1:0]   rspData;
   logic            rfOpcode;
   logic [AW-1:0]   rfSelect;
   logic [DW-1:0]   rfDataIn;
   logic [DW-1:0]   rfDataOut;

   regfile_arbiter #(
      .NUM_REQ    (N),
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .LOCK_MAX   (LOCK_MAX)
   ) dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_reqValid  (reqValid),
      .i_reqWrite  (reqWrite),
      .i_reqLock   (reqLock),
      .i_reqSelect (reqSelect),
      .i_reqData   (reqData),
      .o_reqReady  (reqReady),
      .o_rspValid  (rspValid),
      .o_rspData   (rspData),
      .o_rfOpcode  (rfOpcode),
      .o_rfSelect  (rfSelect),
      .o_rfDataIn  (rfDataIn),
      .i_rfDataOut (rfDataOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RegisterFile: write or registered read, one per clock.
   logic [DW-1:0] rfMem [RF_NUM_REGS];
   always @(posedge clk) begin
      if (rfOpcode == RF_OP_WRITE) rfMem[rfSelect] <= rfDataIn;
      else                         rfDataOut <= rfMem[rfSelect];
   end

   int checkCount = 0;
   int passCount  = 0;

   logic [N-1:0]  cValid, cWrite, cLock;
   logic [AW-1:0] cSel  [N];
   logic [DW-1:0] cData [N];

   typedef struct {
      logic       rst;
      logic [3:0] valid;
      logic [3:0] write;
      logic [3:0] lock;
      logic [3:0] expReady;
      logic [3:0] expRsp;
      logic       expOp;
   } vec_t;
   vec_t vecs[$];

   task automatic addVec(input logic r, input logic [3:0] v, input logic [3:0] w,
                         input logic [3:0] l, input logic [3:0] er, input logic [3:0] ers,
                         input logic eo);
      vec_t x;
      x.rst = r; x.valid = v; x.write = w; x.lock = l;
      x.expReady = er; x.expRsp = ers; x.expOp = eo;
      vecs.push_back(x);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
   endtask

   task automatic drivePins();
      reqValid = cValid;
      reqWrite = cWrite;
      reqLock  = cLock;
      for (int i = 0; i < N; i++) begin
         reqSelect[i*AW +: AW] = cSel[i];
         reqData[i*DW +: DW]   = cData[i];
      end
   endtask

   task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [3:0] w,
                                input logic [3:0] l);
      @(posedge clk);
      #1;
      reset  = r;
      cValid = v;
      cWrite = w;
      cLock  = l;
      for (int i = 0; i < N; i++) begin
         cSel[i]  = AW'(i + 4);
         cData[i] = DW'(16'hA000 + i);
      end
      drivePins();
   endtask

   // Reference model state: round-robin pointer, lock owner (-1 = none),
   // beats spent locked, pending read response and a shadow of the registers.
   int            mPtr, mOwner, mHold, mRspIdx;
   logic [DW-1:0] mRspData;
   logic          mRspKnown;
   logic [DW-1:0] shadow [RF_NUM_REGS];
   logic          shadowKnown [RF_NUM_REGS];
   logic [AW-1:0] mLastSel;
   logic [DW-1:0] mLastData;
   logic          mLastKnown;

   function automatic int pickWinner();
      if (mOwner >= 0) return cValid[mOwner] ? mOwner : -1;
      for (int k = 0; k < N; k++) begin
         if (cValid[(mPtr + k) % N]) return (mPtr + k) % N;
      end
      return -1;
   endfunction

   task automatic modelReset();
      mPtr = 0; mOwner = -1; mHold = 0; mRspIdx = -1; mLastKnown = 1'b0;
   endtask

   task automatic modelStep(input int winner);
      mRspIdx = -1;
      if (winner >= 0) begin
         mLastSel   = cSel[winner];
         mLastData  = cData[winner];
         mLastKnown = 1'b1;
         if (cWrite[winner]) begin
            shadow[cSel[winner]]      = cData[winner];
            shadowKnown[cSel[winner]] = 1'b1;
         end else begin
            mRspIdx   = winner;
            mRspData  = shadow[cSel[winner]];
            mRspKnown = shadowKnown[cSel[winner]];
         end
      end
      if (mOwner < 0) begin
         if (winner >= 0) begin
            mPtr = (winner + 1) % N;
            if (cLock[winner]) begin
               mOwner = winner;
               mHold  = 1;
            end
         end
      end else if ((winner >= 0 && !cLock[winner]) || mHold == LOCK_MAX) begin
         mPtr   = (mOwner + 1) % N;
         mOwner = -1;
      end else begin
         mHold++;
      end
   endtask

   initial begin
      logic [N-1:0] lastGrant;
      logic [3:0]   expReady;
      logic [3:0]   expRsp;
      int           winner;
      logic         rst;

      reset = 1'b1;
      cValid = '0; cWrite = '0; cLock = '0;
      for (int i = 0; i < N; i++) begin
         cSel[i] = '0; cData[i] = '0;
      end
      drivePins();

      // Plain round robin over four readers, responses trail by one cycle.
      addVec(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      for (int i = 0; i < 8; i++) begin
         addVec(0, 4'hF, 4'h0, 4'h0, 4'(1 << (i % 4)), (i == 0) ? 4'h0 : 4'(1 << ((i - 1) % 4)), 0);
      end
      addVec(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 0);
      addVec(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      // R2 locks for three beats while the others wait.
      addVec(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      addVec(0, 4'h4, 4'hF, 4'h4, 4'h4, 4'h0, 1);
      addVec(0, 4'hF, 4'hF, 4'h4, 4'h4, 4'h0, 1);
      addVec(0, 4'hF, 4'hF, 4'h0, 4'h4, 4'h0, 1);
      addVec(0, 4'hF, 4'hF, 4'h0, 4'h8, 4'h0, 1);
      addVec(0, 4'hF, 4'hF, 4'h0, 4'h1, 4'h0, 1);
      addVec(0, 4'hF, 4'hF, 4'h0, 4'h2, 4'h0, 1);
      // R1 never releases: one ARB beat plus LOCK_MAX HOLD beats, then R2.
      addVec(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      addVec(0, 4'h2, 4'hF, 4'h2, 4'h2, 4'h0, 1);
      for (int i = 0; i < LOCK_MAX; i++) addVec(0, 4'h6, 4'hF, 4'h2, 4'h2, 4'h0, 1);
      addVec(0, 4'h6, 4'hF, 4'h2, 4'h4, 4'h0, 1);
      // Reset right after a read: response dropped, no grant, pointer back to 0.
      addVec(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      addVec(0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 0);
      addVec(1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      addVec(0, 4'hF, 4'h0, 4'h0, 4'h1, 4'h0, 0);
      addVec(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 0);
      // Idle for five cycles.
      addVec(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      for (int i = 0; i < 5; i++) addVec(0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].write, vecs[i].lock);
         @(negedge clk);
         checkOutput($sformatf("vec%0d reqReady", i), 32'(reqReady), 32'(vecs[i].expReady));
         checkOutput($sformatf("vec%0d rspValid", i), 32'(rspValid), 32'(vecs[i].expRsp));
         checkOutput($sformatf("vec%0d rfOpcode", i), 32'(rfOpcode), 32'(vecs[i].expOp));
      end

      // Write R3 from requester 0, read it back through requester 1 next cycle.
      applyStimulus(1, 4'h0, 4'h0, 4'h0);
      applyStimulus(0, 4'h0, 4'h0, 4'h0);
      cValid = 4'h1; cWrite = 4'h1; cSel[0] = 4'd3; cData[0] = 16'hBEEF;
      drivePins();
      @(negedge clk);
      checkOutput("beef write ready", 32'(reqReady), 32'h1);
      checkOutput("beef write opcode", 32'(rfOpcode), 32'h1);
      checkOutput("beef write select", 32'(rfSelect), 32'h3);
      checkOutput("beef write data", 32'(rfDataIn), 32'hBEEF);
      @(posedge clk);
      #1;
      cValid = 4'h2; cWrite = 4'h0; cSel[1] = 4'd3; cData[1] = 16'h0;
      drivePins();
      @(negedge clk);
      checkOutput("beef read ready", 32'(reqReady), 32'h2);
      checkOutput("beef read opcode", 32'(rfOpcode), 32'h0);
      @(posedge clk);
      #1;
      cValid = 4'h0;
      drivePins();
      @(negedge clk);
      checkOutput("beef rspValid", 32'(rspValid), 32'h2);
      checkOutput("beef rspData", 32'(rspData), 32'hBEEF);

      // Randomized traffic against the reference model.
      for (int r = 0; r < RF_NUM_REGS; r++) shadowKnown[r] = 1'b0;
      applyStimulus(1, 4'h0, 4'h0, 4'h0);
      modelReset();
      lastGrant = '0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         @(posedge clk);
         #1;
         rst = ($urandom_range(0, 59) == 0);
         reset = rst;
         for (int i = 0; i < N; i++) begin
            if (!(cValid[i] && !lastGrant[i])) begin
               cValid[i] = ($urandom_range(0, 2) != 0);
               cWrite[i] = $urandom_range(0, 1) == 1;
               cLock[i]  = (i == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 4) == 0);
               cSel[i]   = AW'($urandom_range(0, 7));
               cData[i]  = DW'($urandom);
            end
         end
         drivePins();
         @(negedge clk);
         expRsp = (rst || mRspIdx < 0) ? 4'h0 : 4'(1 << mRspIdx);
         checkOutput("rnd rspValid", 32'(rspValid), 32'(expRsp));
         if (!rst && mRspIdx >= 0 && mRspKnown) begin
            checkOutput("rnd rspData", 32'(rspData), 32'(mRspData));
         end
         winner   = rst ? -1 : pickWinner();
         expReady = (winner < 0) ? 4'h0 : 4'(1 << winner);
         checkOutput("rnd reqReady", 32'(reqReady), 32'(expReady));
         checkOutput("rnd rfOpcode", 32'(rfOpcode), (winner >= 0) ? 32'(cWrite[winner]) : 32'h0);
         if (winner >= 0) begin
            checkOutput("rnd rfSelect", 32'(rfSelect), 32'(cSel[winner]));
            checkOutput("rnd rfDataIn", 32'(rfDataIn), 32'(cData[winner]));
         end else if (!rst && mLastKnown) begin
            checkOutput("rnd rfSelect hold", 32'(rfSelect), 32'(mLastSel));
            checkOutput("rnd rfDataIn hold", 32'(rfDataIn), 32'(mLastData));
         end
         lastGrant = expReady;
         if (rst) modelReset();
         else     modelStep(winner);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
